// File: rtl/lighting_system.sv
`default_nettype none
// ============================================================================
// lighting_system : shade/lamp controller driven by time-of-day, with lamp
//                   count ramped toward a target at a programmable step rate
// Revision 1.0
// ============================================================================
module lighting_system (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  tcode,
  input  logic [3:0]  ulight,
  input  logic [3:0]  lenght,
  output logic [3:0]  wshade,
  output logic [3:0]  lightnum,
  output logic [15:0] lightstate
);

  localparam logic [3:0] C_MORNING = 4'b0001;
  localparam logic [3:0] C_DAY     = 4'b0010;
  localparam logic [3:0] C_EVENING = 4'b0100;
  localparam logic [3:0] C_NIGHT   = 4'b1000;

  logic [3:0] w_shade;
  logic [3:0] w_target;
  logic [3:0] w_period;
  logic [3:0] w_last;
  logic [3:0] r_cnt;

  // Unrecognised codes (none or several bits set) fall back to everything off.
  always_comb begin
    w_shade  = 4'b0000;
    w_target = 4'd0;
    case (tcode)
      C_MORNING: begin
        w_shade  = 4'b0011;
        w_target = ulight >> 1;
      end
      C_DAY: begin
        w_shade  = 4'b1111;
        w_target = 4'd0;
      end
      C_EVENING: begin
        w_shade  = 4'b0011;
        w_target = ulight;
      end
      C_NIGHT: begin
        w_shade  = 4'b0000;
        w_target = ulight;
      end
      default: begin
        w_shade  = 4'b0000;
        w_target = 4'd0;
      end
    endcase
  end

  assign w_period = (lenght == 4'd0) ? 4'd1 : lenght;
  assign w_last   = w_period - 4'd1;

  // ">=" rather than "==" so a shortened period mid-ramp steps on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wshade   <= 4'b0000;
      lightnum <= 4'd0;
      r_cnt    <= 4'd0;
    end else begin
      wshade <= w_shade;
      if (lightnum == w_target) begin
        r_cnt <= 4'd0;
      end else if (r_cnt >= w_last) begin
        r_cnt    <= 4'd0;
        lightnum <= (lightnum < w_target) ? lightnum + 4'd1 : lightnum - 4'd1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  generate
    for (genvar k = 0; k < 16; k++) begin : g_therm
      assign lightstate[k] = (lightnum > 4'(k));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lighting_system.sv
`default_nettype none
// Bench for lighting_system: directed vector table, mid-ramp sequences and a
// randomized run compared against a cycle-level behavioural model.
module tb_lighting_system;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tcode;
  logic [3:0]  ulight;
  logic [3:0]  lenght;
  logic [3:0]  wshade;
  logic [3:0]  lightnum;
  logic [15:0] lightstate;

  int errors = 0;
  int checks = 0;

  int m_shade = 0;
  int m_num   = 0;
  int m_wait  = 0;

  typedef struct {
    logic       r;
    logic [3:0] tc;
    logic [3:0] ul;
    logic [3:0] len;
    int         cyc;
    int         sh;
    int         num;
  } vec_t;

  vec_t vecs[$];

  lighting_system dut (
    .clk        (clk),
    .rst        (rst),
    .tcode      (tcode),
    .ulight     (ulight),
    .lenght     (lenght),
    .wshade     (wshade),
    .lightnum   (lightnum),
    .lightstate (lightstate)
  );

  always #5 clk = ~clk;

  function automatic int therm(input int n);
    return ((1 << n) - 1) & 32'hFFFF;
  endfunction

  task automatic mode(input logic [3:0] tc, input logic [3:0] ul, output int sh, output int tgt);
    case (tc)
      4'b0001: begin sh = 3;  tgt = ul / 2; end
      4'b0010: begin sh = 15; tgt = 0;      end
      4'b0100: begin sh = 3;  tgt = ul;     end
      4'b1000: begin sh = 0;  tgt = ul;     end
      default: begin sh = 0;  tgt = 0;      end
    endcase
  endtask

  // Advance one clock; the model counts cycles spent waiting since the last step.
  task automatic tick();
    int sh, tgt, p;
    mode(tcode, ulight, sh, tgt);
    p = (lenght == 0) ? 1 : int'(lenght);
    if (rst) begin
      m_shade = 0; m_num = 0; m_wait = 0;
    end else begin
      m_shade = sh;
      if (m_num == tgt) begin
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= p) begin
          m_num  = (m_num < tgt) ? m_num + 1 : m_num - 1;
          m_wait = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_out(input string name, input int sh, input int num);
    chk({name, " wshade"}, int'(wshade), sh);
    chk({name, " lightnum"}, int'(lightnum), num);
    chk({name, " lightstate"}, int'(lightstate), therm(num));
  endtask

  task automatic add(input logic r, input logic [3:0] tc, input logic [3:0] ul,
                     input logic [3:0] len, input int cyc, input int sh, input int num);
    vec_t v;
    v.r = r; v.tc = tc; v.ul = ul; v.len = len; v.cyc = cyc; v.sh = sh; v.num = num;
    vecs.push_back(v);
  endtask

  initial begin
    int sel;
    rst = 1'b1; tcode = 4'b0000; ulight = 4'd0; lenght = 4'd0;

    add(1'b1, 4'b0000, 4'd0,  4'd0, 2,  0,  0);
    add(1'b0, 4'b0100, 4'd9,  4'd5, 1,  3,  0);
    add(1'b0, 4'b0100, 4'd9,  4'd5, 4,  3,  1);
    add(1'b0, 4'b0100, 4'd9,  4'd5, 40, 3,  9);
    add(1'b0, 4'b0100, 4'd9,  4'd5, 10, 3,  9);
    add(1'b0, 4'b0001, 4'd9,  4'd5, 4,  3,  9);
    add(1'b0, 4'b0001, 4'd9,  4'd5, 1,  3,  8);
    add(1'b0, 4'b0001, 4'd9,  4'd5, 20, 3,  4);
    add(1'b0, 4'b0010, 4'd9,  4'd0, 1,  15, 3);
    add(1'b0, 4'b0010, 4'd9,  4'd0, 3,  15, 0);
    add(1'b0, 4'b1000, 4'd15, 4'd1, 1,  0,  1);
    add(1'b0, 4'b1000, 4'd15, 4'd1, 14, 0,  15);
    add(1'b0, 4'b0000, 4'd15, 4'd1, 15, 0,  0);
    add(1'b0, 4'b0011, 4'd7,  4'd1, 3,  0,  0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; tcode = vecs[i].tc; ulight = vecs[i].ul; lenght = vecs[i].len;
      run(vecs[i].cyc);
      chk($sformatf("vec%0d", i), int'(wshade), vecs[i].sh);
      chk($sformatf("vec%0d num", i), int'(lightnum), vecs[i].num);
      chk($sformatf("vec%0d state", i), int'(lightstate), therm(vecs[i].num));
    end

    // Redirect downward mid-ramp: must settle on the new target without overshoot.
    rst = 1'b1; run(1);
    rst = 1'b0; tcode = 4'b0100; ulight = 4'd10; lenght = 4'd3;
    run(7);  chk_out("ramp_pre", 3, 2);
    ulight = 4'd1;
    run(1);  chk_out("redir_hold", 3, 2);
    run(1);  chk_out("redir_step", 3, 1);
    run(10); chk_out("redir_settle", 3, 1);

    // Shortened period with counter already past the new limit.
    rst = 1'b1; run(1);
    rst = 1'b0; tcode = 4'b1000; ulight = 4'd5; lenght = 4'd8;
    run(6);  chk_out("plong_wait", 0, 0);
    lenght = 4'd3;
    run(1);  chk_out("pshort_step", 0, 1);

    // Reset mid-ramp.
    tcode = 4'b0100;
    run(4);  chk_out("pre_rst", 3, 2);
    rst = 1'b1;
    run(1);  chk_out("mid_rst", 0, 0);
    rst = 1'b0;

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) begin
        sel = $urandom_range(0, 9);
        tcode = (sel < 8) ? (4'b0001 << (sel % 4)) : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 24) == 0) ulight = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) lenght = 4'($urandom_range(0, 4));
      tick();
      chk("rand wshade", int'(wshade), m_shade);
      chk("rand lightnum", int'(lightnum), m_num);
      chk("rand lightstate", int'(lightstate), therm(m_num));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
